// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Instruction-fetch stage of the RV32I five-stage pipeline. It owns the PC,
// drives the I-cache read handshake and loads the IF/ID pipeline register
// that decode consumes. It honours memory-stage stalls (MA_stall), decode
// hazard bubbles (bubble) and branch redirects (br_taken/br_target). A
// redirect can arrive while a cache read is still outstanding.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   br_taken        redirect request from execute (flushes IF/ID)
//   br_target       redirect PC, valid with br_taken
//   MA_stall        memory-stage stall: freezes IF/ID and PC
//   bubble          decode hazard: IF/ID holds its contents
//   icache_read     read request, held until icache_resp
//   icache_address  fetch address, stable while icache_read=1
//   icache_rdata    instruction word, valid with icache_resp
//   icache_resp     one-cycle completion pulse (may be same cycle as read)
//   PC_out          IF/ID PC
//   instr_out       IF/ID instruction
//   false_NOP       IF/ID holds an injected NOP
//   IF_stall        fetch has no instruction to deliver this cycle
//   fetch_count     real instructions loaded into IF/ID (perf counter)
//   stall_count     cycles with IF_stall=1 (perf counter)
//
// Configuration macro: IF_PERF_CNT_EN
//   defined   -> fetch_count / stall_count are live 32-bit wrapping counters
//   undefined -> counter logic is not built; both outputs are tied to 0
//
// States:
//   FETCH  request at pc outstanding; the response is used
//   DRAIN  request at the old pc outstanding but superseded by a redirect;
//          its response is discarded, then fetch resumes at redirect_pc
//   HOLD   a fetched word is parked in hold_instr waiting for IF/ID to free
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        MA_stall,
  input  logic        bubble,
  output logic        icache_read,
  output logic [31:0] icache_address,
  input  logic [31:0] icache_rdata,
  input  logic        icache_resp,
  output logic [31:0] PC_out,
  output logic [31:0] instr_out,
  output logic        false_NOP,
  output logic        IF_stall,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic        false_nop_q, false_nop_d;

  logic advance;
  logic redirect;
  logic real_load;

  // A stalled memory stage swallows the branch; execute re-presents it later.
  assign advance  = !MA_stall && !bubble;
  assign redirect = br_taken && !MA_stall;

  // Next-state, PC and IF/ID computation.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    hold_instr_d  = hold_instr_q;
    pc_out_d      = pc_out_q;
    instr_out_d   = instr_out_q;
    false_nop_d   = false_nop_q;
    real_load     = 1'b0;

    case (state_q)
      FETCH: begin
        if (icache_resp) begin
          if (redirect) begin
            pc_d        = br_target;
            pc_out_d    = 32'h0000_0000;
            instr_out_d = NOP_INSTR;
            false_nop_d = 1'b1;
          end else if (advance) begin
            pc_out_d    = pc_q;
            instr_out_d = icache_rdata;
            false_nop_d = 1'b0;
            pc_d        = pc_q + 32'd4;
            real_load   = 1'b1;
          end else begin
            // IF/ID is blocked: park the word so the cache is released.
            hold_instr_d = icache_rdata;
            state_d      = HOLD;
          end
        end else begin
          if (redirect) begin
            // The request must complete at its original address; remember
            // where to go once it does.
            redirect_pc_d = br_target;
            pc_out_d      = 32'h0000_0000;
            instr_out_d   = NOP_INSTR;
            false_nop_d   = 1'b1;
            state_d       = DRAIN;
          end else if (advance) begin
            pc_out_d    = 32'h0000_0000;
            instr_out_d = NOP_INSTR;
            false_nop_d = 1'b1;
          end else begin
            pc_out_d = pc_out_q;
          end
        end
      end

      DRAIN: begin
        if (redirect || advance) begin
          pc_out_d    = 32'h0000_0000;
          instr_out_d = NOP_INSTR;
          false_nop_d = 1'b1;
        end else begin
          pc_out_d = pc_out_q;
        end
        if (redirect) begin
          redirect_pc_d = br_target;
        end else begin
          redirect_pc_d = redirect_pc_q;
        end
        if (icache_resp) begin
          // Stale word is dropped; the latest redirect target wins.
          pc_d    = redirect ? br_target : redirect_pc_q;
          state_d = FETCH;
        end else begin
          state_d = DRAIN;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d        = br_target;
          pc_out_d    = 32'h0000_0000;
          instr_out_d = NOP_INSTR;
          false_nop_d = 1'b1;
          state_d     = FETCH;
        end else if (advance) begin
          pc_out_d    = pc_q;
          instr_out_d = hold_instr_q;
          false_nop_d = 1'b0;
          pc_d        = pc_q + 32'd4;
          real_load   = 1'b1;
          state_d     = FETCH;
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      redirect_pc_q <= RESET_PC;
      hold_instr_q  <= NOP_INSTR;
      pc_out_q      <= 32'h0000_0000;
      instr_out_q   <= NOP_INSTR;
      false_nop_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      hold_instr_q  <= hold_instr_d;
      pc_out_q      <= pc_out_d;
      instr_out_q   <= instr_out_d;
      false_nop_q   <= false_nop_d;
    end
  end

  // pc is only changed on a response or from HOLD, so the address is stable
  // for the lifetime of every request.
  assign icache_read    = !rst && (state_q != HOLD);
  assign icache_address = pc_q;
  assign IF_stall       = ((state_q == FETCH) && !icache_resp) || (state_q == DRAIN);

  assign PC_out    = pc_out_q;
  assign instr_out = instr_out_q;
  assign false_NOP = false_nop_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Performance counter increments (wrap naturally at 32 bits).
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (real_load) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end else begin
      fetch_count_d = fetch_count_q;
    end
    if (IF_stall) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= 32'h0000_0000;
      stall_count_q <= 32'h0000_0000;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`else
  logic unused_real_load;
  assign unused_real_load = real_load;
  assign fetch_count      = 32'h0000_0000;
  assign stall_count      = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// Testbench for instruction_fetch.
//
// A driver issues one cycle of stimulus at a time (directed scenarios, then
// random traffic) and plays the I-cache with a per-request latency of 0..3
// cycles. A transaction-level reference model tracks "which address is the
// outstanding request for", "will its data be thrown away", "where fetch
// resumes" and "is a fetched word waiting", and pushes the expected IF/ID
// contents (and perf counters) for every edge into a queue. A separate
// monitor pops and compares one entry after each rising edge.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        MA_stall;
  logic        bubble;
  logic        icache_read;
  logic [31:0] icache_address;
  logic [31:0] icache_rdata;
  logic        icache_resp;
  logic [31:0] PC_out;
  logic [31:0] instr_out;
  logic        false_NOP;
  logic        IF_stall;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  instruction_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .MA_stall      (MA_stall),
    .bubble        (bubble),
    .icache_read   (icache_read),
    .icache_address(icache_address),
    .icache_rdata  (icache_rdata),
    .icache_resp   (icache_resp),
    .PC_out        (PC_out),
    .instr_out     (instr_out),
    .false_NOP     (false_NOP),
    .IF_stall      (IF_stall),
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        nop;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_addr;      // address of the current/next request
  logic        m_stale;     // outstanding request will be discarded
  logic [31:0] m_resume;    // where fetch continues after a stale request
  logic        m_have_word; // a fetched word waits for IF/ID
  logic [31:0] m_word;
  logic [31:0] e_pc, e_instr, e_fcnt, e_scnt;
  logic        e_nop;

  // Cache responder state
  int age;
  int lat;
  bit lat_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nop_into_ifid();
    e_pc    = 32'h0000_0000;
    e_instr = 32'h0000_0013;
    e_nop   = 1'b1;
  endtask

  task automatic real_into_ifid(input logic [31:0] a, input logic [31:0] w);
    e_pc    = a;
    e_instr = w;
    e_nop   = 1'b0;
    e_fcnt  = e_fcnt + 32'd1;
  endtask

  // One clock cycle of stimulus, checking and model update.
  task automatic step(input bit r, input bit br, input logic [31:0] tgt,
                      input bit ma, input bit bub, input int forced_lat);
    bit exp_read, exp_stall, adv, redir;
    exp_t e;
    @(negedge clk);
    rst       = r;
    br_taken  = br;
    br_target = tgt;
    MA_stall  = ma;
    bubble    = bub;
    exp_read  = !r && !m_have_word;
    if (exp_read) begin
      if (!lat_valid) begin
        lat       = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 3));
        lat_valid = 1'b1;
      end
      icache_resp = (age == lat);
    end else begin
      icache_resp = r ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    icache_rdata = icache_resp ? mem_word(icache_address) : $urandom;
    #1;
    check32("icache_read", {31'd0, icache_read}, {31'd0, exp_read});
    if (exp_read) check32("icache_address", icache_address, m_addr);
    if (!r) begin
      exp_stall = !m_have_word && (m_stale || !icache_resp);
      check32("IF_stall", {31'd0, IF_stall}, {31'd0, exp_stall});
    end else begin
      exp_stall = 1'b0;
    end

    // Reference model: effect of the coming rising edge
    adv   = !ma && !bub;
    redir = br && !ma;
    if (r) begin
      m_addr = 32'h0000_0060; m_stale = 1'b0; m_resume = 32'h0;
      m_have_word = 1'b0; m_word = 32'h0;
      nop_into_ifid();
      e_fcnt = 32'h0; e_scnt = 32'h0;
    end else begin
      if (exp_stall) e_scnt = e_scnt + 32'd1;
      if (m_have_word) begin
        if (redir) begin
          m_addr = tgt; m_have_word = 1'b0; nop_into_ifid();
        end else if (adv) begin
          real_into_ifid(m_addr, m_word); m_addr = m_addr + 32'd4; m_have_word = 1'b0;
        end
      end else if (m_stale) begin
        if (redir) m_resume = tgt;
        if (redir || adv) nop_into_ifid();
        if (icache_resp) begin
          m_addr = m_resume; m_stale = 1'b0;
        end
      end else if (icache_resp) begin
        if (redir) begin
          m_addr = tgt; nop_into_ifid();
        end else if (adv) begin
          real_into_ifid(m_addr, mem_word(m_addr)); m_addr = m_addr + 32'd4;
        end else begin
          m_have_word = 1'b1; m_word = mem_word(m_addr);
        end
      end else if (redir) begin
        m_stale = 1'b1; m_resume = tgt; nop_into_ifid();
      end else if (adv) begin
        nop_into_ifid();
      end
    end

    // Responder bookkeeping for the coming edge
    if (r || icache_resp) begin
      age = 0; lat_valid = 1'b0;
    end else if (exp_read) begin
      age++;
    end

    e.pc = e_pc; e.instr = e_instr; e.nop = e_nop;
`ifdef IF_PERF_CNT_EN
    e.fcnt = e_fcnt; e.scnt = e_scnt;
`else
    e.fcnt = 32'h0; e.scnt = 32'h0;
`endif
    exp_q.push_back(e);
  endtask

  // Monitor: compare IF/ID and counters after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check32("PC_out", PC_out, e.pc);
        check32("instr_out", instr_out, e.instr);
        check32("false_NOP", {31'd0, false_NOP}, {31'd0, e.nop});
        check32("fetch_count", fetch_count, e.fcnt);
        check32("stall_count", stall_count, e.scnt);
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    rst = 1'b1; br_taken = 1'b0; br_target = 32'h0; MA_stall = 1'b0;
    bubble = 1'b0; icache_resp = 1'b0; icache_rdata = 32'h0;
    m_addr = 32'h60; m_stale = 1'b0; m_resume = 32'h0; m_have_word = 1'b0;
    m_word = 32'h0; e_pc = 32'h0; e_instr = 32'h13; e_nop = 1'b1;
    e_fcnt = 32'h0; e_scnt = 32'h0; age = 0; lat = 0; lat_valid = 1'b0;

    // Reset, then same-cycle-hit streaming from 0x60
    step(1, 0, 32'h0, 0, 0, 0);
    step(1, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 0, 0);
    // 3-cycle miss
    for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 0, 0, 3);
    // Branch to 0x100 one cycle into a 3-cycle miss
    step(0, 0, 32'h0, 0, 0, 3);
    step(0, 1, 32'h100, 0, 0, 3);
    for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 0, 0, 0);
    // Bubble for two cycles coincident with a response
    step(0, 0, 32'h0, 0, 1, 0);
    step(0, 0, 32'h0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 0, 0);
    // MA_stall together with br_taken, then branch re-presented
    step(0, 1, 32'h200, 1, 0, 0);
    step(0, 1, 32'h200, 1, 1, 0);
    step(0, 1, 32'h200, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 0, 0);
    // Reset while draining a superseded request
    step(0, 0, 32'h0, 0, 0, 3);
    step(0, 1, 32'h300, 0, 0, 3);
    step(1, 0, 32'h0, 0, 0, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 0, 0);
    // PC wrap
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, tgt,
           $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0, -1);
    end

    @(negedge clk);
    @(negedge clk);
    check32("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the RV32I five-stage pipeline. Owns the PC and the I-cache read handshake, and loads the IF/ID pipeline register consumed by instruction decode. It honours memory-stage stalls, decode hazard bubbles and branch redirects, including redirects that arrive while a cache read is outstanding.

## Interface
- RESET_PC, 32'h0000_0060, PC value loaded on reset.
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- br_taken  in  1  redirect request from execute; flush IF/ID.
- br_target  in  32  redirect PC, valid with br_taken.
- MA_stall  in  1  memory-stage stall; freezes IF/ID and PC.
- bubble  in  1  decode hazard; IF/ID must hold its contents.
- icache_read  out  1  read request; held until icache_resp.
- icache_address  out  32  fetch address; stable while icache_read=1.
- icache_rdata  in  32  instruction word, valid with icache_resp.
- icache_resp  in  1  one-cycle completion pulse; may arrive in the same cycle as icache_read.
- PC_out  out  32  IF/ID PC.
- instr_out  out  32  IF/ID instruction.
- false_NOP  out  1  IF/ID holds an injected NOP, not a fetched instruction.
- IF_stall  out  1  fetch has no instruction to deliver this cycle.
- fetch_count  out  32  perf counter; see Configuration.
- stall_count  out  32  perf counter; see Configuration.

## Operation
- Internal signals:
  - advance = !MA_stall && !bubble.
  - redirect = br_taken && !MA_stall.
  - redirect takes priority over bubble.
- NOP load: PC_out=0, instr_out=32'h0000_0013, false_NOP=1.
- FETCH state:
  - icache_read=1, icache_address=pc.
  - icache_resp && redirect: discard rdata; pc<=br_target; NOP load; stay in FETCH.
  - icache_resp && advance: IF/ID<={pc, rdata}; false_NOP<=0; pc<=pc+4; stay in FETCH.
  - icache_resp && !advance && !redirect: hold_instr<=rdata; go to HOLD; IF/ID unchanged.
  - no resp && redirect: redirect_pc<=br_target; NOP load; go to DRAIN.
  - no resp && advance: NOP load.
  - no resp && !advance: IF/ID unchanged.
- DRAIN state:
  - icache_read=1, icache_address=old pc (the address is never changed mid-request).
  - redirect: redirect_pc<=br_target (latest wins); NOP load.
  - advance without redirect: NOP load.
  - icache_resp: discard rdata; pc<=redirect_pc (or br_target if redirect in the same cycle); go to FETCH.
- HOLD state:
  - icache_read=0.
  - redirect: drop hold_instr; pc<=br_target; NOP load; go to FETCH.
  - advance: IF/ID<={pc, hold_instr}; false_NOP<=0; pc<=pc+4; go to FETCH.
  - otherwise: stay in HOLD.
- IF_stall = (FETCH && !icache_resp) || DRAIN.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - state=FETCH, pc=RESET_PC.
  - PC_out=0, instr_out=32'h13, false_NOP=1.
  - counters=0.
  - icache_read=0 while rst=1.
- Cycle after reset: icache_read=1, icache_address=RESET_PC.
- Latency: an instruction appears on IF/ID the cycle after its icache_resp edge, if advancing.
- Throughput: one instruction per cycle with a same-cycle-hit cache.
- A cache latency of N cycles inserts N NOPs into IF/ID.
- icache_read is never deasserted before icache_resp, and icache_address never changes while icache_read=1.
- Simultaneous MA_stall and br_taken: the branch is ignored; execute re-presents it after MA_stall drops.
- rst overrides everything, including mid-DRAIN. No response is expected for an abandoned request; any resp arriving in the reset cycle is ignored.

## Configuration
- IF_PERF_CNT_EN defined:
  - fetch_count increments each cycle a real instruction (false_NOP<=0) loads into IF/ID.
  - stall_count increments each cycle IF_stall=1.
  - Both counters are 32-bit, wrap to 0, and are cleared by rst.
- IF_PERF_CNT_EN undefined: counter logic is not compiled; fetch_count and stall_count are tied to 0.

## Test plan
- Reset with RESET_PC=0x60 and a same-cycle-hit cache returning addr-derived words -> PC_out=0x60,0x64,0x68 on consecutive cycles; false_NOP=0; IF_stall=0.
- Cache latency of 3 cycles at 0x60 -> IF_stall=1 for 3 cycles, 3 NOPs into IF/ID, then PC_out=0x60; icache_address stable throughout.
- br_taken=1 with target 0x100 one cycle into a 3-cycle miss -> NOP load; icache_address stays 0x60 until resp; stale word never reaches IF/ID; next request address=0x100.
- bubble=1 for 2 cycles, coincident with resp for 0x64 -> HOLD; icache_read=0; IF/ID unchanged 2 cycles; then PC_out=0x64 with the held word; next address=0x68.
- MA_stall=1 and br_taken=1 together -> IF/ID and pc unchanged; redirect to target only when MA_stall=0.
- rst asserted in DRAIN -> next cycle icache_address=0x60; PC_out=0; instr_out=0x13. With IF_PERF_CNT_EN, counters read 0.
